// File: rtl/falafel_req_arbiter.sv
// Round-robin request arbiter in front of falafel_core: N client ports share one alloc slot,
// one free slot and one response register, with an order FIFO routing responses back to requesters.
module falafel_req_arbiter #(
  parameter int DATA_W      = 64,
  parameter int N_PORTS     = 4,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [N_PORTS-1:0]                 req_val_i,
  output logic [N_PORTS-1:0]                 req_rdy_o,
  input  logic [N_PORTS-1:0]                 req_is_free_i,
  input  logic [N_PORTS*DATA_W-1:0]          req_data_i,
  output logic [N_PORTS-1:0]                 rsp_val_o,
  input  logic [N_PORTS-1:0]                 rsp_rdy_i,
  output logic [DATA_W-1:0]                  rsp_data_o,
  output logic                               alloc_fifo_empty_o,
  input  logic                               alloc_fifo_read_i,
  output logic [DATA_W-1:0]                  alloc_fifo_dout_o,
  output logic                               free_fifo_empty_o,
  input  logic                               free_fifo_read_i,
  output logic [DATA_W-1:0]                  free_fifo_dout_o,
  output logic                               resp_fifo_full_o,
  input  logic                               resp_fifo_write_i,
  input  logic [DATA_W-1:0]                  resp_fifo_din_i,
  output logic [$clog2(ORDER_DEPTH+1)-1:0]   outstanding_o,
  output logic                               err_o
);

  localparam int PW = $clog2(N_PORTS);
  localparam int AW = $clog2(ORDER_DEPTH);
  localparam int CW = $clog2(ORDER_DEPTH+1);

  logic              alloc_vld, free_vld, resp_vld, err_q;
  logic [DATA_W-1:0] alloc_data, free_data, resp_data;
  logic [PW-1:0]     last_grant;

  logic [PW-1:0]     order_mem [ORDER_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     order_cnt;
  logic              order_full, order_empty;
  logic [PW-1:0]     head_port;

  logic [N_PORTS-1:0] eligible;
  logic               grant_vld, grant_is_free;
  logic [PW-1:0]      grant_idx;
  logic [DATA_W-1:0]  grant_data;
  logic               alloc_push, free_push, rsp_pop, resp_accept, err_set;

  assign order_full  = (order_cnt == CW'(ORDER_DEPTH));
  assign order_empty = (order_cnt == '0);
  assign head_port   = order_mem[rd_ptr];

  // Eligibility looks only at registered state, so a slot being read this cycle stays blocked.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (req_is_free_i[p]) eligible[p] = req_val_i[p] & ~free_vld;
      else                  eligible[p] = req_val_i[p] & ~alloc_vld & ~order_full;
    end
  end

  always_comb begin : arb
    logic [PW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = PW'((int'(last_grant) + i) % N_PORTS);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (!rst_ni) grant_vld = 1'b0;
    req_rdy_o = '0;
    if (grant_vld) req_rdy_o[grant_idx] = 1'b1;
  end

  always_comb begin
    grant_data    = '0;
    grant_is_free = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (PW'(p) == grant_idx) begin
        grant_data    = req_data_i[p*DATA_W +: DATA_W];
        grant_is_free = req_is_free_i[p];
      end
    end
  end

  assign alloc_push  = grant_vld & ~grant_is_free;
  assign free_push   = grant_vld & grant_is_free;
  assign rsp_pop     = resp_vld & rsp_rdy_i[head_port];
  assign resp_accept = resp_fifo_write_i & ~resp_vld & ~order_empty;
  assign err_set     = (alloc_fifo_read_i & ~alloc_vld) | (free_fifo_read_i & ~free_vld) |
                       (resp_fifo_write_i & ~resp_accept);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_vld  <= 1'b0;
      alloc_data <= '0;
    end else if (alloc_push) begin
      alloc_vld  <= 1'b1;
      alloc_data <= grant_data;
    end else if (alloc_fifo_read_i) begin
      alloc_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_vld  <= 1'b0;
      free_data <= '0;
    end else if (free_push) begin
      free_vld  <= 1'b1;
      free_data <= grant_data;
    end else if (free_fifo_read_i) begin
      free_vld  <= 1'b0;
    end
  end

  // Order FIFO holds the requesting port of every outstanding alloc, oldest at rd_ptr.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      order_cnt <= '0;
    end else begin
      if (alloc_push) wr_ptr <= wr_ptr + 1'b1;
      if (rsp_pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({alloc_push, rsp_pop})
        2'b10:   order_cnt <= order_cnt + 1'b1;
        2'b01:   order_cnt <= order_cnt - 1'b1;
        default: order_cnt <= order_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_push) order_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_vld  <= 1'b0;
      resp_data <= '0;
    end else if (resp_accept) begin
      resp_vld  <= 1'b1;
      resp_data <= resp_fifo_din_i;
    end else if (rsp_pop) begin
      resp_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= PW'(N_PORTS-1);
      err_q      <= 1'b0;
    end else begin
      if (grant_vld) last_grant <= grant_idx;
      if (err_set)   err_q      <= 1'b1;
    end
  end

  always_comb begin
    rsp_val_o = '0;
    if (resp_vld) rsp_val_o[head_port] = 1'b1;
  end

  assign rsp_data_o         = resp_data;
  assign alloc_fifo_empty_o = ~alloc_vld;
  assign alloc_fifo_dout_o  = alloc_data;
  assign free_fifo_empty_o  = ~free_vld;
  assign free_fifo_dout_o   = free_data;
  assign resp_fifo_full_o   = resp_vld;
  assign outstanding_o      = order_cnt;
  assign err_o              = err_q;

endmodule
